// File: rtl/io_pkg.sv
// io_pkg: constants and types shared by keypad and display blocks.
// Holds FSM encodings, scan divider default and a row priority helper.
package io_pkg;

  localparam int SCAN_DIV_DEF = 100000;
  localparam int KP_W         = 4;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2
  } kp_state_t;

  // Lowest-index low row wins when several are pressed.
  function automatic logic [1:0] first_low(input logic [KP_W-1:0] r);
    if (!r[0])      return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else            return 2'd3;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running divider, one-cycle tick every DIV clocks.
// Shared by keypad scan and display multiplex timing.
module tick_gen
  import io_pkg::*;
#(
  parameter int DIV = SCAN_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == W'(DIV - 1));
  assign tick   = w_last;

  // Count 0..DIV-1 and wrap on the tick cycle.
  always_ff @(posedge clk) begin
    if (rst)         r_cnt <= '0;
    else if (w_last) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/keypad_hex_entry.sv
// keypad_hex_entry: 4x4 keypad scanner with debounce and hex entry.
// Accepted keys shift into a 16-bit register for display echo.
module keypad_hex_entry
  import io_pkg::*;
#(
  parameter int SCAN_DIV       = SCAN_DIV_DEF,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [KP_W-1:0] row,
  output logic [KP_W-1:0] col,
  input  logic            clr,
  output logic            key_valid,
  output logic [3:0]      key_code,
  output logic [15:0]     entry_data,
  output logic [2:0]      digit_count
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] DT_M = CW'(DEBOUNCE_TICKS);

  logic [KP_W-1:0] r_row_m;
  logic [KP_W-1:0] r_row_s;
  kp_state_t       r_state;
  kp_state_t       w_state_n;
  logic [1:0]      r_col;
  logic [1:0]      w_col_n;
  logic [1:0]      r_row_idx;
  logic [1:0]      w_row_n;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_n;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_tick;
  logic            w_strobe;
  logic            w_idle;

  tick_gen #(.DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_idle    = (r_row_s == 4'hF);
  assign col       = ~(4'b0001 << r_col);

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_m <= '1;
      r_row_s <= '1;
    end else begin
      r_row_m <= row;
      r_row_s <= r_row_m;
    end
  end

  // Scan/debounce/hold next-state and strobe decode.
  always_comb begin
    w_state_n = r_state;
    w_col_n   = r_col;
    w_row_n   = r_row_idx;
    w_cnt_n   = r_cnt;
    w_strobe  = 1'b0;
    unique case (r_state)
      ST_SCAN: begin
        if (w_tick) begin
          if (!w_idle) begin
            w_row_n   = first_low(r_row_s);
            w_cnt_n   = '0;
            w_state_n = ST_DEBOUNCE;
          end else begin
            w_col_n = r_col + 2'd1;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (w_tick) begin
          if (!r_row_s[r_row_idx]) begin
            if (w_cnt_inc == DT_M) begin
              w_strobe  = 1'b1;
              w_cnt_n   = '0;
              w_state_n = ST_HOLD;
            end else begin
              w_cnt_n = w_cnt_inc;
            end
          end else begin
            w_cnt_n   = '0;
            w_state_n = ST_SCAN;
          end
        end
      end
      ST_HOLD: begin
        if (w_tick) begin
          if (w_idle) begin
            if (w_cnt_inc == DT_M) begin
              w_cnt_n   = '0;
              w_state_n = ST_SCAN;
            end else begin
              w_cnt_n = w_cnt_inc;
            end
          end else begin
            w_cnt_n = '0;
          end
        end
      end
      default: begin
        w_state_n = ST_SCAN;
        w_cnt_n   = '0;
      end
    endcase
  end

  // FSM state, frozen column, latched row and shared counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_SCAN;
      r_col     <= 2'd0;
      r_row_idx <= 2'd0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_n;
      r_col     <= w_col_n;
      r_row_idx <= w_row_n;
      r_cnt     <= w_cnt_n;
    end
  end

  // Strobe, held key code and shifting entry register; clr wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid   <= 1'b0;
      key_code    <= 4'h0;
      entry_data  <= 16'h0;
      digit_count <= 3'd0;
    end else begin
      key_valid <= w_strobe;
      if (w_strobe) key_code <= {r_row_idx, r_col};
      if (clr) begin
        entry_data  <= 16'h0;
        digit_count <= 3'd0;
      end else if (w_strobe) begin
        entry_data  <= {entry_data[11:0], r_row_idx, r_col};
        digit_count <= (digit_count == 3'd4) ? 3'd4
                                             : digit_count + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_keypad_hex_entry.sv
// tb_keypad_hex_entry: directed bench with a keypad matrix model
// and an entry-register scoreboard checked every cycle.
module tb_keypad_hex_entry;

  localparam int SD = 4;
  localparam int DT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] entry_data;
  logic [2:0]  digit_count;

  logic [15:0] keys = 16'h0;
  int n_chk = 0;
  int n_pass = 0;
  int n_strobes = 0;
  logic [3:0] exp_q[$];
  logic [15:0] m_entry = 16'h0;
  int m_cnt = 0;
  logic [3:0] m_code = 4'h0;
  logic prev_kv = 1'b0;
  logic last_rst = 1'b1;
  logic last_clr = 1'b0;

  always #5 clk = ~clk;

  keypad_hex_entry #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DT)) dut (
    .clk         (clk),
    .rst         (rst),
    .row         (row),
    .col         (col),
    .clr         (clr),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .entry_data  (entry_data),
    .digit_count (digit_count)
  );

  // Physical matrix: a pressed key shorts its row to its column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !col[c]) row[r] = 1'b0;
  end

  always @(posedge clk) begin
    last_rst <= rst;
    last_clr <= clr;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard: codes come from the expected queue, entry is a
  // 4-digit shift register with a saturating count.
  initial begin
    forever begin
      @(negedge clk);
      if (last_rst) begin
        m_entry = 16'h0;
        m_cnt   = 0;
        m_code  = 4'h0;
        prev_kv = 1'b0;
        check("rst_kv", key_valid, 0);
        check("rst_col", col, 4'b1110);
      end else begin
        if (key_valid) begin
          n_strobes++;
          check("strobe_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) m_code = exp_q.pop_front();
        end
        if (last_clr) begin
          m_entry = 16'h0;
          m_cnt   = 0;
        end else if (key_valid) begin
          m_entry = {m_entry[11:0], m_code};
          m_cnt   = (m_cnt < 4) ? m_cnt + 1 : 4;
        end
        check("entry", entry_data, m_entry);
        check("count", digit_count, m_cnt);
        check("code", key_code, m_code);
        check("col_onecold", $countones(~col), 1);
        check("kv_single", key_valid && prev_kv, 0);
        prev_kv = key_valid;
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_strobe(string name, output int k);
    k = 0;
    while (exp_q.size() != 0 && k < 120) begin
      cyc(1);
      k++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_col(logic [3:0] c);
    logic [3:0] p;
    int k;
    k = 0;
    p = col;
    cyc(1);
    while (!(p != c && col == c) && k < 60) begin
      p = col;
      cyc(1);
      k++;
    end
    check("wait_col", col, c);
  endtask

  task automatic press(logic [15:0] mask, logic [3:0] code, string name);
    int k;
    exp_q.push_back(code);
    keys = mask;
    wait_strobe(name, k);
    cyc(2);
    keys = 16'h0;
    cyc(24);
  endtask

  initial begin
    logic [3:0] seq[5];
    int idx;
    int run;
    int k;
    int n0;
    seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // Idle after reset: rotation every SD clocks, no strobes.
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    idx = 0;
    run = 0;
    for (int i = 0; i < 24 && idx < 4; i++) begin
      @(negedge clk);
      if (col != seq[idx]) begin
        if (idx > 0) check("idle_run", run, SD);
        idx++;
        check("idle_col", col, seq[idx]);
        run = 0;
      end
      run++;
    end
    check("idle_steps", idx, 4);
    check("idle_entry", entry_data, 16'h0);
    check("idle_strobes", n_strobes, 0);
    cyc(1);

    // Clean press of row 2, column 1.
    press(16'h0200, 4'h9, "clean_press");
    check("clean_entry", entry_data, 16'h0009);
    check("clean_count", digit_count, 1);
    check("clean_code", key_code, 4'h9);

    // Bouncy press of key 0.
    exp_q.push_back(4'h0);
    wait_col(4'b1110);
    keys = 16'h0001;
    cyc(SD);
    keys = 16'h0;
    cyc(SD);
    keys = 16'h0001;
    wait_strobe("bouncy_press", k);
    check("bouncy_latency_ok", k >= DT * SD, 1);
    cyc(2);
    keys = 16'h0;
    cyc(24);
    check("bouncy_entry", entry_data, 16'h0090);
    check("bouncy_count", digit_count, 2);
    check("bouncy_strobes", n_strobes, 2);

    // Five entries: oldest digits fall off.
    for (int d = 1; d <= 5; d++)
      press(16'h1 << d, 4'(d), "five_press");
    check("five_entry", entry_data, 16'h2345);
    check("five_count", digit_count, 4);
    check("five_code", key_code, 4'h5);

    // clr collides with the strobe for key F.
    exp_q.push_back(4'hF);
    keys = 16'h8000;
    clr = 1'b1;
    wait_strobe("clr_press", k);
    clr = 1'b0;
    cyc(2);
    keys = 16'h0;
    cyc(24);
    check("clr_entry", entry_data, 16'h0);
    check("clr_count", digit_count, 0);
    check("clr_code", key_code, 4'hF);

    // Reset in the middle of debounce.
    n0 = n_strobes;
    wait_col(4'b1101);
    keys = 16'h0020;
    cyc(2 * SD);
    rst = 1'b1;
    keys = 16'h0;
    cyc(1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_col", col, 4'b1110);
    check("rst_mid_kv", key_valid, 0);
    check("rst_mid_code", key_code, 4'h0);
    cyc(40);
    check("rst_no_strobe", n_strobes, n0);

    // Two rows in one column: lower row index wins.
    press(16'h1010, 4'h4, "two_rows");
    check("two_rows_code", key_code, 4'h4);
    check("two_rows_entry", entry_data, 16'h0004);

    // Second key during HOLD is ignored.
    n0 = n_strobes;
    exp_q.push_back(4'h6);
    keys = 16'h0040;
    wait_strobe("hold_first", k);
    cyc(2);
    keys = 16'h0440;
    cyc(20);
    keys = 16'h0;
    cyc(40);
    check("hold_strobes", n_strobes, n0 + 1);
    check("hold_entry", entry_data, 16'h0046);
    check("hold_count", digit_count, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
